// File: rtl/mux_4way_pkg.sv
// Shared constants for the gate-level primitive library.
// Select codes are used by the multi-way selectors.
package mux_4way_pkg;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux_2way.sv
// Two-way selector built only from NAND gates: out = sel ? inB : inA.
// The same sel drives every bit of the vector.
module mux_2way #(
   parameter int WIDTH = 1
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] sel_v;
   logic [WIDTH-1:0] nsel_v;
   logic [WIDTH-1:0] nand_a;
   logic [WIDTH-1:0] nand_b;

   // A NAND with both inputs tied together acts as the inverter.
   assign sel_v  = {WIDTH{sel}};
   assign nsel_v = ~(sel_v & sel_v);
   assign nand_a = ~(inA & nsel_v);
   assign nand_b = ~(inB & sel_v);
   assign out    = ~(nand_a & nand_b);

endmodule

// File: rtl/mux_4way.sv
// Four-way selector as a two-stage tree of mux_2way, plus a registered
// copy of the result for pipelined consumers.
module mux_4way
   import mux_4way_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       select,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [WIDTH-1:0] inC,
   input  logic [WIDTH-1:0] inD,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] outReg
);

   logic [WIDTH-1:0] ab_out;
   logic [WIDTH-1:0] cd_out;
   logic [WIDTH-1:0] tree_out;

   mux_2way #(.WIDTH(WIDTH)) u_stage1_ab (
      .sel (select[0]),
      .inA (inA),
      .inB (inB),
      .out (ab_out)
   );

   mux_2way #(.WIDTH(WIDTH)) u_stage1_cd (
      .sel (select[0]),
      .inA (inC),
      .inB (inD),
      .out (cd_out)
   );

   mux_2way #(.WIDTH(WIDTH)) u_stage2 (
      .sel (select[1]),
      .inA (ab_out),
      .inB (cd_out),
      .out (tree_out)
   );

   // NOTE: every path through this block assigns out, so no latch is
   // inferred; the default arm makes an unknown select visible as X in
   // simulation instead of letting the gate tree quietly pick an input.
   always_comb begin
      case (select)
         SEL_A, SEL_B, SEL_C, SEL_D: out = tree_out;
         default:                    out = {WIDTH{1'bx}};
      endcase
   end

   // NOTE: registered state uses non-blocking assignment so every reader
   // sees the pre-edge value within the same time step.
   always_ff @(posedge clk) begin
      if (reset) outReg <= '0;
      else       outReg <= out;
   end

endmodule

// File: tb/tb_mux_4way.sv
// Self-checking bench for mux_4way: a WIDTH=1 and a WIDTH=8 instance
// checked against an array-indexed reference model.
module tb_mux_4way;

   logic       clk = 1'b0;
   logic       reset;

   logic [1:0] sel1;
   logic       a1, b1, c1, d1;
   logic       out1, out_reg1;

   logic [1:0] sel8;
   logic [7:0] a8, b8, c8, d8;
   logic [7:0] out8, out_reg8;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_4way #(.WIDTH(1)) dut1 (
      .clk    (clk),
      .reset  (reset),
      .select (sel1),
      .inA    (a1),
      .inB    (b1),
      .inC    (c1),
      .inD    (d1),
      .out    (out1),
      .outReg (out_reg1)
   );

   mux_4way #(.WIDTH(8)) dut8 (
      .clk    (clk),
      .reset  (reset),
      .select (sel8),
      .inA    (a8),
      .inB    (b8),
      .inC    (c8),
      .inD    (d8),
      .out    (out8),
      .outReg (out_reg8)
   );

   // Reference: the select code is simply an index into the input list.
   function automatic logic [7:0] ref_mux(input logic [1:0] s, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c,
                                          input logic [7:0] d);
      logic [7:0] ins [4];
      ins = '{a, b, c, d};
      return ins[s];
   endfunction

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step_edge();
      n_checks++;
      if (out_reg1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outreg1: got %b expected 0", out_reg1);
      end
      n_checks++;
      if (out_reg8 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outreg8: got %h expected 00", out_reg8);
      end
      reset = 1'b0;
   endtask

   task automatic test_zero();
      {a1, b1, c1, d1} = 4'b0000;
      for (int s = 0; s < 2; s++) begin
         sel1 = 2'(s);
         #1;
         n_checks++;
         if (out1 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_sel%0d: got %b expected 0", s, out1);
         end
      end
   endtask

   task automatic test_directed();
      // {select, A, B, C, D, expected}
      logic [6:0] vec [5];
      logic       exp_v;
      vec = '{7'b10_0111_1, 7'b00_1010_1, 7'b01_1100_1, 7'b11_1110_0, 7'b11_0111_1};
      for (int i = 0; i < 5; i++) begin
         {sel1, a1, b1, c1, d1, exp_v} = vec[i];
         #1;
         n_checks++;
         if (out1 !== exp_v) begin
            n_fail++;
            $display("FAIL directed_%0d: got %b expected %b", i, out1, exp_v);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [7:0] exp_v;
      for (int i = 0; i < 64; i++) begin
         {sel1, a1, b1, c1, d1} = 6'(i);
         #1;
         exp_v = ref_mux(sel1, {7'b0, a1}, {7'b0, b1}, {7'b0, c1}, {7'b0, d1});
         n_checks++;
         if (out1 !== exp_v[0]) begin
            n_fail++;
            $display("FAIL exhaustive_%0d: got %b expected %b", i, out1, exp_v[0]);
         end
      end
   endtask

   task automatic test_wide();
      logic [7:0] exp_tbl [4];
      exp_tbl = '{8'h11, 8'h22, 8'h44, 8'h88};
      a8 = 8'h11; b8 = 8'h22; c8 = 8'h44; d8 = 8'h88;
      for (int s = 0; s < 4; s++) begin
         sel8 = 2'(s);
         #1;
         n_checks++;
         if (out8 !== exp_tbl[s]) begin
            n_fail++;
            $display("FAIL wide_out_sel%0d: got %h expected %h", s, out8, exp_tbl[s]);
         end
         step_edge();
         n_checks++;
         if (out_reg8 !== exp_tbl[s]) begin
            n_fail++;
            $display("FAIL wide_outreg_sel%0d: got %h expected %h", s, out_reg8, exp_tbl[s]);
         end
      end
   endtask

   task automatic test_reset_midop();
      sel1 = 2'b00; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
      step_edge();
      reset = 1'b1;
      step_edge();
      n_checks++;
      if (out_reg1 !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_outreg_cleared: got %b expected 0", out_reg1);
      end
      n_checks++;
      if (out1 !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_out_tracks: got %b expected 1", out1);
      end
      reset = 1'b0;
      step_edge();
      n_checks++;
      if (out_reg1 !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_outreg_release: got %b expected 1", out_reg1);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_out;
      logic [7:0] exp_reg;
      for (int i = 0; i < 200; i++) begin
         sel8  = 2'($urandom_range(3));
         a8    = 8'($urandom);
         b8    = 8'($urandom);
         c8    = 8'($urandom);
         d8    = 8'($urandom);
         reset = ($urandom_range(7) == 0);
         #1;
         exp_out = ref_mux(sel8, a8, b8, c8, d8);
         exp_reg = reset ? 8'h00 : exp_out;
         n_checks++;
         if (out8 !== exp_out) begin
            n_fail++;
            $display("FAIL random_out_%0d: got %h expected %h", i, out8, exp_out);
         end
         step_edge();
         n_checks++;
         if (out_reg8 !== exp_reg) begin
            n_fail++;
            $display("FAIL random_outreg_%0d: got %h expected %h", i, out_reg8, exp_reg);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      sel1 = 2'b00; {a1, b1, c1, d1} = 4'b0000;
      sel8 = 2'b00; {a8, b8, c8, d8} = 32'h0;
      #2;
      test_reset();
      test_zero();
      test_directed();
      test_exhaustive();
      test_wide();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
